msrv32_pipe_ctrl: RTL and testbench

- Pipeline sequencer for the msrv32 core. It generates the enables and the flush/bubble control for the PC register, the stage-1 register block and the stage-2 register block (stage 2→3).
- Handles instruction/data memory wait states, taken-branch flushes and trap entry.
- All control outputs are decoded from a registered FSM state (Moore), so there is no combinational input-to-output path.

---
 rtl/msrv32_pipe_ctrl.sv | 148 ++++++++++++++
 tb/tb_msrv32_pipe_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_pipe_ctrl.sv
// msrv32 pipeline sequencer: PC/stage enables and bubble control for wait states, branches and traps.
// Optional MEM_WAIT watchdog enabled by defining MSRV32_MEM_TIMEOUT_EN.
module msrv32_pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16,
    parameter int TIMEOUT      = 255
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             imem_ready_in,
    input  logic             dmem_req_in,
    input  logic             dmem_ready_in,
    input  logic             branch_taken_in,
    input  logic             trap_taken_in,
    output logic             pc_en_out,
    output logic             reg1_en_out,
    output logic             reg2_en_out,
    output logic             flush_out,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] stall_cnt_out,
    output logic             mem_timeout_out
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2,
        TRAP     = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t     state;
    state_t     state_nx;
    logic [3:0] flush_cnt;
    logic [3:0] flush_cnt_nx;
    logic       mem_wait;

    assign mem_wait = (dmem_req_in & ~dmem_ready_in) | ~imem_ready_in;

`ifdef MSRV32_MEM_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_cnt_nx;
    logic            wd_expired;

    // wd_cnt holds the number of MEM_WAIT cycles so far, including the current one
    assign wd_expired = (state == MEM_WAIT) && (wd_cnt == WD_W'(TIMEOUT));
    assign wd_cnt_nx  = (state == MEM_WAIT) ? wd_cnt + WD_W'(1) : WD_W'(1);
`endif

    always_comb begin
        state_nx     = state;
        flush_cnt_nx = flush_cnt;
        unique case (state)
            RUN: begin
                if (trap_taken_in) begin
                    state_nx = TRAP;
                end else if (branch_taken_in) begin
                    state_nx     = FLUSH;
                    flush_cnt_nx = FLUSH_INIT;
                end else if (mem_wait) begin
                    state_nx = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                // a stage-3 branch held during the wait is only acted on at exit
                if (trap_taken_in) begin
                    state_nx = TRAP;
                end else if (!mem_wait) begin
                    if (branch_taken_in) begin
                        state_nx     = FLUSH;
                        flush_cnt_nx = FLUSH_INIT;
                    end else begin
                        state_nx = RUN;
                    end
                end
`ifdef MSRV32_MEM_TIMEOUT_EN
                else if (wd_expired) begin
                    state_nx = TRAP;
                end
`endif
            end
            FLUSH: begin
                if (trap_taken_in) begin
                    state_nx = TRAP;
                end else if (flush_cnt <= 4'd1) begin
                    state_nx = RUN;
                end else begin
                    flush_cnt_nx = flush_cnt - 4'd1;
                end
            end
            TRAP: begin
                state_nx     = FLUSH;
                flush_cnt_nx = FLUSH_INIT;
            end
            default: begin
                state_nx     = FLUSH;
                flush_cnt_nx = FLUSH_INIT;
            end
        endcase
    end

    // outputs are registered from the next state so they change exactly with the state
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state         <= FLUSH;
            flush_cnt     <= FLUSH_INIT;
            pc_en_out     <= 1'b1;
            reg1_en_out   <= 1'b1;
            reg2_en_out   <= 1'b1;
            flush_out     <= 1'b1;
            state_out     <= FLUSH;
            stall_cnt_out <= '0;
        end else begin
            state         <= state_nx;
            flush_cnt     <= flush_cnt_nx;
            pc_en_out     <= (state_nx != MEM_WAIT);
            reg1_en_out   <= (state_nx != MEM_WAIT);
            reg2_en_out   <= (state_nx != MEM_WAIT);
            flush_out     <= (state_nx == FLUSH) || (state_nx == TRAP);
            state_out     <= state_nx;
            if ((state == MEM_WAIT) && (stall_cnt_out != '1)) begin
                stall_cnt_out <= stall_cnt_out + CNT_W'(1);
            end
        end
    end

`ifdef MSRV32_MEM_TIMEOUT_EN
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wd_cnt          <= '0;
            mem_timeout_out <= 1'b0;
        end else begin
            if (state_nx == MEM_WAIT) begin
                wd_cnt <= wd_cnt_nx;
            end else begin
                wd_cnt <= '0;
            end
            mem_timeout_out <= (state_nx == MEM_WAIT) && (wd_cnt_nx == WD_W'(TIMEOUT));
        end
    end
`else
    assign mem_timeout_out = 1'b0;
`endif

endmodule

// File: tb/tb_msrv32_pipe_ctrl.sv
// Scoreboard bench for msrv32_pipe_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_msrv32_pipe_ctrl;

    localparam int FC  = 2;
    localparam int CW  = 6;
    localparam int TO  = 4;
    localparam int MAXSTALL = (1 << CW) - 1;

    localparam int M_RUN   = 0;
    localparam int M_WAIT  = 1;
    localparam int M_FLUSH = 2;
    localparam int M_TRAP  = 3;

    typedef struct packed {
        logic          pc;
        logic          r1;
        logic          r2;
        logic          fl;
        logic [1:0]    st;
        logic [CW-1:0] stall;
        logic          to;
    } exp_t;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          imem_ready_in, dmem_req_in, dmem_ready_in, branch_taken_in, trap_taken_in;
    logic          pc_en_out, reg1_en_out, reg2_en_out, flush_out, mem_timeout_out;
    logic [1:0]    state_out;
    logic [CW-1:0] stall_cnt_out;

    exp_t expQ[$];
    exp_t monExp;
    exp_t resetExp;
    int   checks = 0;
    int   errors = 0;

    int mState, flushLeft, waitCycles, stallTotal;

    msrv32_pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .imem_ready_in(imem_ready_in), .dmem_req_in(dmem_req_in), .dmem_ready_in(dmem_ready_in),
        .branch_taken_in(branch_taken_in), .trap_taken_in(trap_taken_in),
        .pc_en_out(pc_en_out), .reg1_en_out(reg1_en_out), .reg2_en_out(reg2_en_out),
        .flush_out(flush_out), .state_out(state_out), .stall_cnt_out(stall_cnt_out),
        .mem_timeout_out(mem_timeout_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic modelReset();
        mState     = M_FLUSH;
        flushLeft  = FC;
        waitCycles = 0;
        stallTotal = 0;
    endtask

    function automatic exp_t modelOutputs();
        exp_t e;
        bit enabled = (mState != M_WAIT);
        e.pc    = enabled;
        e.r1    = enabled;
        e.r2    = enabled;
        e.fl    = (mState == M_FLUSH) || (mState == M_TRAP);
        e.st    = 2'(mState);
        e.stall = CW'((stallTotal > MAXSTALL) ? MAXSTALL : stallTotal);
`ifdef MSRV32_MEM_TIMEOUT_EN
        e.to    = (mState == M_WAIT) && (waitCycles == TO);
`else
        e.to    = 1'b0;
`endif
        return e;
    endfunction

    // one clock of the pipeline rules: trap beats branch beats memory wait
    task automatic modelStep(input bit imem, input bit req, input bit rdy, input bit br, input bit tr);
        bit w = (req && !rdy) || !imem;
        int nxt = mState;
        if (mState == M_WAIT) stallTotal++;
        case (mState)
            M_RUN: begin
                if (tr) nxt = M_TRAP;
                else if (br) begin nxt = M_FLUSH; flushLeft = FC; end
                else if (w) nxt = M_WAIT;
            end
            M_WAIT: begin
                if (tr) nxt = M_TRAP;
                else if (!w) begin
                    if (br) begin nxt = M_FLUSH; flushLeft = FC; end
                    else nxt = M_RUN;
                end
`ifdef MSRV32_MEM_TIMEOUT_EN
                else if (waitCycles == TO) nxt = M_TRAP;
`endif
            end
            M_FLUSH: begin
                if (tr) nxt = M_TRAP;
                else if (flushLeft == 1) nxt = M_RUN;
                else flushLeft--;
            end
            default: begin nxt = M_FLUSH; flushLeft = FC; end
        endcase
        if (nxt == M_WAIT) waitCycles = (mState == M_WAIT) ? waitCycles + 1 : 1;
        else waitCycles = 0;
        mState = nxt;
    endtask

    task automatic checkOutput(input string name, input exp_t e);
        exp_t a;
        a.pc = pc_en_out; a.r1 = reg1_en_out; a.r2 = reg2_en_out; a.fl = flush_out;
        a.st = state_out; a.stall = stall_cnt_out; a.to = mem_timeout_out;
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL %s t=%0t got pc=%b r1=%b r2=%b fl=%b st=%0d stall=%0d to=%b expected pc=%b r1=%b r2=%b fl=%b st=%0d stall=%0d to=%b",
                     name, $time, a.pc, a.r1, a.r2, a.fl, a.st, a.stall, a.to,
                     e.pc, e.r1, e.r2, e.fl, e.st, e.stall, e.to);
        end
    endtask

    // called just after a falling edge; drives inputs for the next rising edge
    task automatic applyStimulus(input bit imem, input bit req, input bit rdy, input bit br, input bit tr);
        imem_ready_in   = imem;
        dmem_req_in     = req;
        dmem_ready_in   = rdy;
        branch_taken_in = br;
        trap_taken_in   = tr;
        modelStep(imem, req, rdy, br, tr);
        expQ.push_back(modelOutputs());
        @(negedge clk_in);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 1, 0, 0);
    endtask

    task automatic randomTraffic(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus($urandom_range(7) != 0, $urandom_range(2) == 0, 1'($urandom_range(1)),
                          $urandom_range(5) == 0, $urandom_range(15) == 0);
    endtask

    // asserts reset between edges and checks outputs before any clock arrives
    task automatic asyncReset(input string name);
        @(posedge clk_in);
        #3;
        reset_in = 1'b1;
        #1;
        checkOutput(name, resetExp);
        @(negedge clk_in);
        reset_in = 1'b0;
        modelReset();
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk_in);
            #1;
            if (expQ.size() > 0) begin
                monExp = expQ.pop_front();
                checkOutput("cycle", monExp);
            end
        end
    end

    initial begin
        resetExp.pc = 1'b1; resetExp.r1 = 1'b1; resetExp.r2 = 1'b1; resetExp.fl = 1'b1;
        resetExp.st = 2'd2; resetExp.stall = '0; resetExp.to = 1'b0;

        reset_in = 1'b1;
        imem_ready_in = 1'b1; dmem_req_in = 1'b0; dmem_ready_in = 1'b1;
        branch_taken_in = 1'b0; trap_taken_in = 1'b0;
        #3;
        checkOutput("reset_state", resetExp);
        @(negedge clk_in);
        @(negedge clk_in);
        reset_in = 1'b0;
        modelReset();

        $display("[TB] reset release and settle into RUN");
        idle(4);

        $display("[TB] data memory wait for three cycles");
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        idle(2);

        $display("[TB] instruction memory wait");
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        idle(2);

        $display("[TB] taken branch in RUN, branch ignored during FLUSH");
        applyStimulus(1, 0, 1, 1, 0);
        applyStimulus(1, 0, 1, 1, 0);
        idle(3);

        $display("[TB] trap and branch together");
        applyStimulus(1, 0, 1, 1, 1);
        idle(5);

        $display("[TB] branch held across a wait, trap inside a wait");
        applyStimulus(1, 1, 0, 1, 0);
        applyStimulus(1, 1, 0, 1, 0);
        applyStimulus(1, 1, 1, 1, 0);
        idle(3);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 1);
        idle(4);

        $display("[TB] long data wait");
        for (int i = 0; i < 7; i++) applyStimulus(1, 1, 0, 0, 0);
        idle(5);

        $display("[TB] asynchronous reset inside MEM_WAIT");
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        asyncReset("async_reset_mem_wait");
        idle(3);

        $display("[TB] randomized traffic");
        randomTraffic(1500);
        asyncReset("async_reset_random");
        randomTraffic(800);

        idle(2);
        repeat (3) @(posedge clk_in);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
